// File: rtl/ctrl_pkg.sv
// Shared constants, state encoding and clamp helper for the command deframer
// and the pan/tilt controller that consumes its output.
package ctrl_pkg;
  localparam int POS_LEN   = 8;
  localparam int STATE_LEN = 2;

  localparam logic [7:0]         HDR_BYTE = 8'hF0;
  localparam logic [7:0]         RST_BYTE = 8'h00;
  localparam logic [POS_LEN-1:0] POS_MIN  = 8'd50;
  localparam logic [POS_LEN-1:0] POS_MAX  = 8'd250;
  localparam logic [POS_LEN-1:0] POS_RST  = 8'd150;

  typedef enum logic [STATE_LEN-1:0] {
    S_IDLE = 2'd0,
    S_X    = 2'd1,
    S_Y    = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  // Keeps servo commands inside the mechanically safe window.
  function automatic logic [POS_LEN-1:0] clamp(input logic [POS_LEN-1:0] v);
    if (v < POS_MIN)      return POS_MIN;
    else if (v > POS_MAX) return POS_MAX;
    else                  return v;
  endfunction
endpackage

// File: rtl/gap_timer.sv
// Inter-byte watchdog: counts idle cycles while a frame is open and pulses
// expired once the allowed gap is used up.
module gap_timer #(
  parameter int GAP_CYC = 21750,
  parameter int GAP_LEN = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam logic [GAP_LEN-1:0] LAST = GAP_LEN'(GAP_CYC - 1);

  logic [GAP_LEN-1:0] cnt;

  // A byte on the expiry cycle suppresses the pulse.
  assign expired = run && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (clear || !run || expired) cnt <= '0;
    else                               cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cmd_deframer.sv
// Parses 4-byte position frames (header, X, Y, checksum) from the UART byte
// stream, clamps accepted positions and decodes the soft-reset command.
module cmd_deframer
  import ctrl_pkg::*;
#(
  parameter int GAP_CYC = 21750,
  parameter int GAP_LEN = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_done,
  output logic [POS_LEN-1:0] pos_x,
  output logic [POS_LEN-1:0] pos_y,
  output logic               pos_valid,
  output logic               soft_rst,
  output logic               busy,
  output logic [7:0]         err_cnt
);
  state_t             state, state_nxt;
  logic [7:0]         sum;
  logic [POS_LEN-1:0] x_raw, y_raw;
  logic               chk_ok, chk_bad, soft_hit, expired, err_hit;

  gap_timer #(.GAP_CYC(GAP_CYC), .GAP_LEN(GAP_LEN)) u_gap (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_done),
    .run     (state != S_IDLE),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    chk_ok    = 1'b0;
    chk_bad   = 1'b0;
    soft_hit  = 1'b0;
    if (rx_done) begin
      case (state)
        S_IDLE: begin
          if (rx_data == HDR_BYTE)      state_nxt = S_X;
          else if (rx_data == RST_BYTE) soft_hit  = 1'b1;
        end
        S_X:  state_nxt = S_Y;
        S_Y:  state_nxt = S_CHK;
        S_CHK: begin
          state_nxt = S_IDLE;
          chk_ok    = (rx_data == sum);
          chk_bad   = (rx_data != sum);
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (expired) begin
      state_nxt = S_IDLE;
    end
  end

  // expired is gated by rx_done, so both error sources are mutually exclusive.
  assign err_hit = chk_bad || expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sum       <= '0;
      x_raw     <= '0;
      y_raw     <= '0;
      pos_x     <= POS_RST;
      pos_y     <= POS_RST;
      pos_valid <= 1'b0;
      soft_rst  <= 1'b0;
      busy      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != S_IDLE);
      pos_valid <= chk_ok;
      soft_rst  <= soft_hit;
      if (rx_done) begin
        case (state)
          S_IDLE:  sum <= HDR_BYTE;
          S_X:     begin x_raw <= rx_data; sum <= sum + rx_data; end
          S_Y:     begin y_raw <= rx_data; sum <= sum + rx_data; end
          default: ;
        endcase
      end
      if (chk_ok) begin
        pos_x <= clamp(x_raw);
        pos_y <= clamp(y_raw);
      end
      if (err_hit && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule
